mealy_seq_detector: RTL and testbench

MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

---
 rtl/mealy_seq_detector.sv | 91 +++++++++
 tb/tb_mealy_seq_detector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_detector.sv
// Serial Mealy pattern detector with a loadable pattern, optional overlap and a
// saturating match counter. The fill counter is the control state and is exported on fill_o.
module mealy_seq_detector #(
   parameter int                 PAT_LEN   = 4,
   parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011,
   parameter int                 OVERLAP   = 1,
   parameter int                 CNT_W     = 8,
   localparam int                FILL_W    = $clog2(PAT_LEN)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               in_i,
   input  logic               valid_i,
   input  logic               load_i,
   input  logic [PAT_LEN-1:0] pat_i,
   output logic               match_o,
   output logic               armed_o,
   output logic [CNT_W-1:0]   count_o,
   output logic [FILL_W-1:0]  fill_o
);

   // Handshake: valid_i high means in_i is taken on this rising edge. There
   // is no ready; the detector never stalls. load_i outranks valid_i.

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [PAT_LEN-1:0] pat_q,   pat_d;
   logic [PAT_LEN-2:0] hist_q,  hist_d;
   logic [FILL_W-1:0]  fill_q,  fill_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               accept;
   logic               full;
   logic               match;
   logic [PAT_LEN-1:0] window;

   assign accept = valid_i & ~load_i;
   assign full   = (fill_q == FILL_MAX);
   assign window = {hist_q, in_i};

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pat_q   <= PAT_RESET;
         hist_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         count_q <= count_d;
      end
   end

   // Next-state logic
   always_comb begin
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      count_d = count_q;
      if (load_i) begin
         pat_d  = pat_i;
         hist_d = '0;
         fill_d = '0;
      end else if (valid_i) begin
         hist_d = window[PAT_LEN-2:0];
         // Non-overlapping mode restarts the fill so the matched bits cannot
         // be reused, while history keeps shifting.
         if ((OVERLAP == 0) && match) begin
            fill_d = '0;
         end else if (!full) begin
            fill_d = fill_q + 1'b1;
         end
      end
      if (match && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Output logic: match is Mealy (depends on the current sample)
   always_comb begin
      match   = accept & full & (window == pat_q);
      match_o = match;
      armed_o = full;
      count_o = count_q;
      fill_o  = fill_q;
   end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector: three instances (default, non-overlap,
// 2-bit counter with 1111), scoreboard queue filled by the driver, drained by a monitor.
module tb_mealy_seq_detector;

   localparam int W = 20;  // {tag[7:0], sel[1:0], match, armed, count[7:0]}

   logic       clk = 1'b0;
   logic       rst_s [3];
   logic       in_s  [3];
   logic       vld_s [3];
   logic       ld_s  [3];
   logic [3:0] pat_s [3];

   logic       match_w [3];
   logic       armed_w [3];
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic [1:0] fill_w [3];

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int tag_n  = 0;

   always #5 clk = ~clk;

   mealy_seq_detector u_ovl (
      .clk_i(clk), .reset_i(rst_s[0]), .in_i(in_s[0]), .valid_i(vld_s[0]),
      .load_i(ld_s[0]), .pat_i(pat_s[0]), .match_o(match_w[0]),
      .armed_o(armed_w[0]), .count_o(cnt0), .fill_o(fill_w[0])
   );

   mealy_seq_detector #(.OVERLAP(0)) u_nov (
      .clk_i(clk), .reset_i(rst_s[1]), .in_i(in_s[1]), .valid_i(vld_s[1]),
      .load_i(ld_s[1]), .pat_i(pat_s[1]), .match_o(match_w[1]),
      .armed_o(armed_w[1]), .count_o(cnt1), .fill_o(fill_w[1])
   );

   mealy_seq_detector #(.PAT_RESET(4'b1111), .CNT_W(2)) u_sat (
      .clk_i(clk), .reset_i(rst_s[2]), .in_i(in_s[2]), .valid_i(vld_s[2]),
      .load_i(ld_s[2]), .pat_i(pat_s[2]), .match_o(match_w[2]),
      .armed_o(armed_w[2]), .count_o(cnt2), .fill_o(fill_w[2])
   );

   // One cycle of stimulus on instance sel; expected outputs for that cycle are queued.
   task automatic step(input int sel, input logic r, input logic v, input logic b,
                       input logic l, input logic [3:0] p, input logic chk,
                       input logic m, input logic a, input logic [7:0] c);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         rst_s[i] = 1'b0; vld_s[i] = 1'b0; ld_s[i] = 1'b0;
      end
      rst_s[sel] = r;
      vld_s[sel] = v;
      in_s[sel]  = b;
      ld_s[sel]  = l;
      pat_s[sel] = p;
      tag_n++;
      if (chk) exp_q.push_back({8'(tag_n), 2'(sel), m, a, c});
   endtask

   task automatic bit_in(input int sel, input logic b, input logic m, input logic a,
                         input logic [7:0] c);
      step(sel, 1'b0, 1'b1, b, 1'b0, 4'b0000, 1'b1, m, a, c);
   endtask

   task automatic idle(input int sel, input logic b, input logic a, input logic [7:0] c);
      step(sel, 1'b0, 1'b0, b, 1'b0, 4'b0000, 1'b1, 1'b0, a, c);
   endtask

   task automatic reset_dut(input int sel, input logic v);
      step(sel, 1'b1, v, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   // Monitor: outputs are sampled mid-cycle, after inputs settle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         int           s;
         logic         am, aa;
         logic [7:0]   ac;
         e  = exp_q.pop_front();
         s  = int'(e[11:10]);
         am = match_w[s];
         aa = armed_w[s];
         ac = (s == 0) ? cnt0 : (s == 1) ? cnt1 : {6'd0, cnt2};
         checks += 3;
         if (am !== e[9]) begin
            errors++;
            $display("FAIL match v%0d inst%0d got=%b exp=%b fill=%0d", e[19:12], s, am, e[9], fill_w[s]);
         end
         if (aa !== e[8]) begin
            errors++;
            $display("FAIL armed v%0d inst%0d got=%b exp=%b fill=%0d", e[19:12], s, aa, e[8], fill_w[s]);
         end
         if (ac !== e[7:0]) begin
            errors++;
            $display("FAIL count v%0d inst%0d got=%0d exp=%0d", e[19:12], s, ac, e[7:0]);
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_s[i] = 1'b0; in_s[i] = 1'b0; vld_s[i] = 1'b0; ld_s[i] = 1'b0; pat_s[i] = 4'd0;
      end

      // Reset state and single match 1011
      reset_dut(0, 1'b0);
      idle(0, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b0, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b1, 1'b1, 8'd0);
      idle(0, 1'b0, 1'b1, 8'd1);

      // Overlapping stream 1011011
      reset_dut(0, 1'b1);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b0, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b1, 1'b1, 8'd0);
      bit_in(0, 1'b0, 1'b0, 1'b1, 8'd1);
      bit_in(0, 1'b1, 1'b0, 1'b1, 8'd1);
      bit_in(0, 1'b1, 1'b1, 1'b1, 8'd1);
      idle(0, 1'b0, 1'b1, 8'd2);

      // Non-overlapping stream 1011011
      reset_dut(1, 1'b0);
      idle(1, 1'b1, 1'b0, 8'd0);
      bit_in(1, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(1, 1'b0, 1'b0, 1'b0, 8'd0);
      bit_in(1, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(1, 1'b1, 1'b1, 1'b1, 8'd0);
      bit_in(1, 1'b0, 1'b0, 1'b0, 8'd1);
      bit_in(1, 1'b1, 1'b0, 1'b0, 8'd1);
      bit_in(1, 1'b1, 1'b0, 1'b0, 8'd1);
      idle(1, 1'b0, 1'b1, 8'd1);

      // Gap with valid low and in toggling
      reset_dut(0, 1'b0);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b0, 1'b0, 1'b0, 8'd0);
      idle(0, 1'b1, 1'b0, 8'd0);
      idle(0, 1'b0, 1'b0, 8'd0);
      idle(0, 1'b1, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b1, 1'b1, 8'd0);
      idle(0, 1'b0, 1'b1, 8'd1);

      // Load 0000 mid-stream; sample in the load cycle would have matched 1011
      bit_in(0, 1'b1, 1'b0, 1'b1, 8'd1);
      bit_in(0, 1'b0, 1'b0, 1'b1, 8'd1);
      bit_in(0, 1'b1, 1'b0, 1'b1, 8'd1);
      step(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 8'd1);
      idle(0, 1'b1, 1'b0, 8'd1);
      bit_in(0, 1'b0, 1'b0, 1'b0, 8'd1);
      bit_in(0, 1'b0, 1'b0, 1'b0, 8'd1);
      bit_in(0, 1'b0, 1'b0, 1'b0, 8'd1);
      bit_in(0, 1'b0, 1'b1, 1'b1, 8'd1);
      idle(0, 1'b0, 1'b1, 8'd2);

      // Reset mid-sequence discards history and restores 1011
      bit_in(0, 1'b1, 1'b0, 1'b1, 8'd2);
      bit_in(0, 1'b0, 1'b0, 1'b1, 8'd2);
      bit_in(0, 1'b1, 1'b0, 1'b1, 8'd2);
      reset_dut(0, 1'b1);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b0, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(0, 1'b1, 1'b1, 1'b1, 8'd0);
      idle(0, 1'b0, 1'b1, 8'd1);

      // Saturation: 2-bit counter, pattern 1111, eight 1s
      reset_dut(2, 1'b0);
      idle(2, 1'b1, 1'b0, 8'd0);
      bit_in(2, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(2, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(2, 1'b1, 1'b0, 1'b0, 8'd0);
      bit_in(2, 1'b1, 1'b1, 1'b1, 8'd0);
      bit_in(2, 1'b1, 1'b1, 1'b1, 8'd1);
      bit_in(2, 1'b1, 1'b1, 1'b1, 8'd2);
      bit_in(2, 1'b1, 1'b1, 1'b1, 8'd3);
      bit_in(2, 1'b1, 1'b1, 1'b1, 8'd3);
      idle(2, 1'b0, 1'b1, 8'd3);
      idle(2, 1'b0, 1'b1, 8'd3);

      // Let the monitor drain, bounded
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
